player_ctrl: RTL and testbench

PLAYER_CTRL -- requirements
Module: player_ctrl

---
 rtl/player_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_player_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// -----------------------------------------------------------------------------
// player_ctrl -- song selection and transport control for a ROM note player.
//
// Three raw push-buttons (next / previous / pause) are synchronised and
// debounced. Each accepted press becomes a single-cycle pulse. A small FSM
// turns those pulses into song selection and a load/run handshake for the
// external note reader. The FSM also detects the end of a song, which is an
// all-zero note word seen while playing.
//
// Optional feature (compile-time macro):
//   PLAYER_AUTO_ADVANCE_EN  defined   : end-of-song advances to the next song
//                                       (wrapping) and reloads, so playback
//                                       is continuous.
//                           undefined : end-of-song stops; sel and start_addr
//                                       are kept.
//
// Parameters:
//   DB_CYCLES    consecutive stable synchronised samples needed to accept a
//                new button level.
//   GUARD_CYCLES cycles after a load during which end-of-song detection is
//                masked. This covers the reader/ROM latency.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   btn_next    raw push-button, active-high: next song
//   btn_pre     raw push-button, active-high: previous song
//   btn_pause   raw push-button, active-high: start / pause / resume
//   last_song   highest valid song index
//   song_base   ROM start address of song `sel` (external combinational table)
//   note_word   note word currently presented to the note reader
//   sel         selected song index
//   start_addr  registered start address handed to the note reader
//   load        one-cycle strobe: the reader loads start_addr
//   run         reader count enable, high exactly while playing
//   eos         one-cycle end-of-song pulse
// -----------------------------------------------------------------------------
module player_ctrl #(
    parameter int DB_CYCLES    = 500000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_pre,
    input  logic        btn_pause,
    input  logic [2:0]  last_song,
    input  logic [15:0] song_base,
    input  logic [11:0] note_word,
    output logic [2:0]  sel,
    output logic [15:0] start_addr,
    output logic        load,
    output logic        run,
    output logic        eos
);

    // Debounce counter only has to reach DB_CYCLES-1.
    localparam int DBW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ONE   = DBW'(1);
    localparam logic [DBW-1:0] DB_ZERO  = DBW'(0);

    // Guard counter has to hold GUARD_CYCLES itself.
    localparam int GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
    localparam logic [GW-1:0] GUARD_ONE  = GW'(1);
    localparam logic [GW-1:0] GUARD_ZERO = GW'(0);

    // Button lane indices inside the packed vectors below.
    localparam int B_NEXT  = 0;
    localparam int B_PRE   = 1;
    localparam int B_PAUSE = 2;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // Next song index, wrapping to 0 after the last valid song.
    function automatic logic [2:0] sel_inc(input logic [2:0] cur, input logic [2:0] last);
        return (cur >= last) ? 3'd0 : cur + 3'd1;
    endfunction

    // Previous song index. It wraps to the last song from 0, and it also
    // clamps there when the current index is beyond the valid range.
    function automatic logic [2:0] sel_dec(input logic [2:0] cur, input logic [2:0] last);
        return ((cur == 3'd0) || (cur > last)) ? last : cur - 3'd1;
    endfunction

    logic [2:0]     btn_raw_s;
    logic [2:0]     sync1_r;
    logic [2:0]     sync2_r;
    logic [2:0]     db_level_r;
    logic [2:0]     db_prev_r;
    logic [DBW-1:0] db_cnt_r [3];
    logic [2:0]     press_s;
    logic           take_next_s;
    logic           take_pre_s;
    logic           take_pause_s;

    state_t         state_r;
    logic [2:0]     sel_r;
    logic [15:0]    start_addr_r;
    logic           load_r;
    logic           run_r;
    logic           eos_r;
    logic [GW-1:0]  guard_r;

    assign btn_raw_s = {btn_pause, btn_pre, btn_next};

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a new level is adopted only after DB_CYCLES consecutive samples
    // that differ from it. Any sample that agrees with the current level
    // restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_level_r <= 3'b000;
            db_prev_r  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= DB_ZERO;
            end
        end else begin
            db_prev_r <= db_level_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == db_level_r[i]) begin
                    db_cnt_r[i] <= DB_ZERO;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_level_r[i] <= sync2_r[i];
                    db_cnt_r[i]   <= DB_ZERO;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                end
            end
        end
    end

    // Rising edge of the debounced level gives a one-cycle press.
    // Priority is next > pre > pause, and the losers are dropped.
    assign press_s      = db_level_r & ~db_prev_r;
    assign take_next_s  = press_s[B_NEXT];
    assign take_pre_s   = press_s[B_PRE] & ~press_s[B_NEXT];
    assign take_pause_s = press_s[B_PAUSE] & ~press_s[B_PRE] & ~press_s[B_NEXT];

    // Transport FSM. run_r is written together with every state change, so it
    // is high exactly in the cycles where the state is PLAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_STOP;
            sel_r        <= 3'd0;
            start_addr_r <= 16'h0000;
            load_r       <= 1'b0;
            run_r        <= 1'b0;
            eos_r        <= 1'b0;
            guard_r      <= GUARD_ZERO;
        end else begin
            load_r <= 1'b0;
            eos_r  <= 1'b0;
            case (state_r)
                ST_STOP: begin
                    run_r <= 1'b0;
                    if (take_next_s) begin
                        sel_r   <= sel_inc(sel_r, last_song);
                        state_r <= ST_LOAD;
                    end else if (take_pre_s) begin
                        sel_r   <= sel_dec(sel_r, last_song);
                        state_r <= ST_LOAD;
                    end else if (take_pause_s) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_STOP;
                    end
                end

                // Single-cycle state. Presses that arrive here are dropped.
                // song_base already reflects the new sel at this point.
                ST_LOAD: begin
                    start_addr_r <= song_base;
                    load_r       <= 1'b1;
                    guard_r      <= GUARD_LOAD;
                    run_r        <= 1'b1;
                    state_r      <= ST_PLAY;
                end

                ST_PLAY: begin
                    if (guard_r != GUARD_ZERO) begin
                        guard_r <= guard_r - GUARD_ONE;
                    end else begin
                        guard_r <= GUARD_ZERO;
                    end
                    if (take_next_s) begin
                        sel_r   <= sel_inc(sel_r, last_song);
                        run_r   <= 1'b0;
                        state_r <= ST_LOAD;
                    end else if (take_pre_s) begin
                        sel_r   <= sel_dec(sel_r, last_song);
                        run_r   <= 1'b0;
                        state_r <= ST_LOAD;
                    end else if (take_pause_s) begin
                        run_r   <= 1'b0;
                        state_r <= ST_PAUSE;
                    end else if ((guard_r == GUARD_ZERO) && (note_word == 12'h000)) begin
                        // End of song. Guard masking keeps the stale word seen
                        // right after a load from ending the song early.
                        eos_r <= 1'b1;
                        run_r <= 1'b0;
`ifdef PLAYER_AUTO_ADVANCE_EN
                        sel_r   <= sel_inc(sel_r, last_song);
                        state_r <= ST_LOAD;
`else
                        state_r <= ST_STOP;
`endif
                    end else begin
                        run_r   <= 1'b1;
                        state_r <= ST_PLAY;
                    end
                end

                // Resume does not reload, so the reader continues from where
                // it paused.
                ST_PAUSE: begin
                    if (take_next_s) begin
                        sel_r   <= sel_inc(sel_r, last_song);
                        run_r   <= 1'b0;
                        state_r <= ST_LOAD;
                    end else if (take_pre_s) begin
                        sel_r   <= sel_dec(sel_r, last_song);
                        run_r   <= 1'b0;
                        state_r <= ST_LOAD;
                    end else if (take_pause_s) begin
                        run_r   <= 1'b1;
                        state_r <= ST_PLAY;
                    end else begin
                        run_r   <= 1'b0;
                        state_r <= ST_PAUSE;
                    end
                end

                default: begin
                    run_r   <= 1'b0;
                    state_r <= ST_STOP;
                end
            endcase
        end
    end

    assign sel        = sel_r;
    assign start_addr = start_addr_r;
    assign load       = load_r;
    assign run        = run_r;
    assign eos        = eos_r;

endmodule

// File: tb/tb_player_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for player_ctrl with DB_CYCLES=4 and GUARD_CYCLES=2.
// Each test task pushes the expected load records (sel, start_addr) onto a
// queue while it drives stimulus. A negedge monitor pops one record for every
// load pulse the DUT produces and compares it.
module tb_player_ctrl;

    localparam int P_NEXT  = 0;
    localparam int P_PRE   = 1;
    localparam int P_PAUSE = 2;

    logic        clk;
    logic        rst;
    logic        btn_next;
    logic        btn_pre;
    logic        btn_pause;
    logic [2:0]  last_song;
    logic [15:0] song_base;
    logic [11:0] note_word;
    logic [2:0]  sel;
    logic [15:0] start_addr;
    logic        load;
    logic        run;
    logic        eos;

    typedef struct packed {
        logic [2:0]  s;
        logic [15:0] a;
    } ld_t;

    ld_t  exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   eos_cnt = 0;
    int   dbl_cnt = 0;
    bit   load_q  = 1'b0;
    bit   eos_q   = 1'b0;
    logic [2:0] exp_sel;

    player_ctrl #(.DB_CYCLES(4), .GUARD_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .btn_next(btn_next), .btn_pre(btn_pre), .btn_pause(btn_pause),
        .last_song(last_song), .song_base(song_base), .note_word(note_word),
        .sel(sel), .start_addr(start_addr), .load(load), .run(run), .eos(eos)
    );

    // External song table: song s starts at 0x0040 + s*0x100.
    function automatic logic [15:0] base_of(input logic [2:0] s);
        return 16'h0040 + {5'd0, s, 8'h00};
    endfunction

    function automatic logic [2:0] m_inc(input logic [2:0] s, input logic [2:0] l);
        return (s >= l) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic logic [2:0] m_dec(input logic [2:0] s, input logic [2:0] l);
        return ((s == 3'd0) || (s > l)) ? l : s - 3'd1;
    endfunction

    assign song_base = base_of(sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every load pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (load === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_unexpected: got load sel=%0d addr=%h, required no load", sel, start_addr);
                end else begin
                    ld_t e;
                    e = exp_q.pop_front();
                    if (sel !== e.s || start_addr !== e.a) begin
                        errors++;
                        $display("FAIL load_value: got sel=%0d addr=%h, required sel=%0d addr=%h", sel, start_addr, e.s, e.a);
                    end
                end
            end
            if (eos === 1'b1) eos_cnt++;
            if ((load === 1'b1 && load_q) || (eos === 1'b1 && eos_q)) dbl_cnt++;
            load_q = (load === 1'b1);
            eos_q  = (eos === 1'b1);
        end else begin
            load_q = 1'b0;
            eos_q  = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            P_NEXT:  btn_next  = v;
            P_PRE:   btn_pre   = v;
            default: btn_pause = v;
        endcase
    endtask

    task automatic tap(input int b);
        set_btn(b, 1'b1);
        step(10);
        set_btn(b, 1'b0);
        step(12);
    endtask

    task automatic wait_load(output bit got);
        got = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (load === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        btn_next = 1'b0; btn_pre = 1'b0; btn_pause = 1'b0;
        last_song = 3'd3; note_word = 12'h123;
        exp_sel = 3'd0;
        step(3);
        checks += 5;
        if (sel !== 3'd0)            begin errors++; $display("FAIL reset_sel: got %0d, required 0", sel); end
        if (start_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h, required 0000", start_addr); end
        if (load !== 1'b0)           begin errors++; $display("FAIL reset_load: got %b, required 0", load); end
        if (run !== 1'b0)            begin errors++; $display("FAIL reset_run: got %b, required 0", run); end
        if (eos !== 1'b0)            begin errors++; $display("FAIL reset_eos: got %b, required 0", eos); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_start;
        exp_q.push_back('{3'd0, 16'h0040});
        tap(P_PAUSE);
        checks += 3;
        if (exp_q.size() != 0) begin errors++; $display("FAIL start_load_count: got %0d pending, required 0", exp_q.size()); end
        if (run !== 1'b1)      begin errors++; $display("FAIL start_run: got %b, required 1", run); end
        if (start_addr !== 16'h0040) begin errors++; $display("FAIL start_addr: got %h, required 0040", start_addr); end
    endtask

    task automatic test_bounce;
        exp_sel = m_inc(exp_sel, last_song);
        exp_q.push_back('{exp_sel, base_of(exp_sel)});
        for (int i = 0; i < 6; i++) begin
            btn_next = 1'b1; step(2);
            btn_next = 1'b0; step(2);
        end
        tap(P_NEXT);
        checks += 3;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bounce_load_count: got %0d pending, required 0", exp_q.size()); end
        if (sel !== 3'd1)      begin errors++; $display("FAIL bounce_sel: got %0d, required 1", sel); end
        if (run !== 1'b1)      begin errors++; $display("FAIL bounce_run: got %b, required 1", run); end
    endtask

    task automatic test_wrap;
        // 1 -> 2 -> 3 -> wrap to 0, then pre from 0 -> 3.
        for (int i = 0; i < 3; i++) begin
            exp_sel = m_inc(exp_sel, last_song);
            exp_q.push_back('{exp_sel, base_of(exp_sel)});
            tap(P_NEXT);
        end
        checks++;
        if (sel !== 3'd0) begin errors++; $display("FAIL wrap_next_sel: got %0d, required 0", sel); end
        exp_sel = m_dec(exp_sel, last_song);
        exp_q.push_back('{exp_sel, base_of(exp_sel)});
        tap(P_PRE);
        checks++;
        if (sel !== 3'd3) begin errors++; $display("FAIL wrap_pre_sel: got %0d, required 3", sel); end
        // sel beyond a shrunken last_song: pre clamps to last_song.
        last_song = 3'd1;
        exp_sel = m_dec(exp_sel, last_song);
        exp_q.push_back('{exp_sel, base_of(exp_sel)});
        tap(P_PRE);
        checks += 2;
        if (sel !== 3'd1)      begin errors++; $display("FAIL clamp_pre_sel: got %0d, required 1", sel); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_load_count: got %0d pending, required 0", exp_q.size()); end
        last_song = 3'd3;
    endtask

    task automatic test_priority;
        exp_sel = m_inc(exp_sel, last_song);
        exp_q.push_back('{exp_sel, base_of(exp_sel)});
        btn_next = 1'b1; btn_pause = 1'b1;
        step(10);
        btn_next = 1'b0; btn_pause = 1'b0;
        step(12);
        checks += 3;
        if (exp_q.size() != 0) begin errors++; $display("FAIL prio_load_count: got %0d pending, required 0", exp_q.size()); end
        if (sel !== exp_sel)   begin errors++; $display("FAIL prio_sel: got %0d, required %0d", sel, exp_sel); end
        if (run !== 1'b1)      begin errors++; $display("FAIL prio_run: got %b, required 1 (not paused)", run); end
    endtask

    task automatic test_pause_resume;
        tap(P_PAUSE);
        checks += 3;
        if (run !== 1'b0)                  begin errors++; $display("FAIL pause_run: got %b, required 0", run); end
        if (start_addr !== base_of(exp_sel)) begin errors++; $display("FAIL pause_addr: got %h, required %h", start_addr, base_of(exp_sel)); end
        if (sel !== exp_sel)               begin errors++; $display("FAIL pause_sel: got %0d, required %0d", sel, exp_sel); end
        tap(P_PAUSE);
        checks += 2;
        if (run !== 1'b1)                  begin errors++; $display("FAIL resume_run: got %b, required 1", run); end
        if (start_addr !== base_of(exp_sel)) begin errors++; $display("FAIL resume_addr: got %h, required %h", start_addr, base_of(exp_sel)); end
    endtask

    task automatic test_eos;
        bit got;
        int e0;
        e0 = eos_cnt;
        // A zero word only in the first cycle after a load is masked by the guard.
        exp_sel = m_inc(exp_sel, last_song);
        exp_q.push_back('{exp_sel, base_of(exp_sel)});
        btn_next = 1'b1;
        wait_load(got);
        checks++;
        if (!got) begin errors++; $display("FAIL eos_a_load_timeout: got no load, required load"); end
        note_word = 12'h000;
        step(1);
        note_word = 12'h123;
        btn_next = 1'b0;
        step(12);
        checks += 2;
        if (eos_cnt != e0) begin errors++; $display("FAIL eos_guard: got %0d eos, required 0", eos_cnt - e0); end
        if (run !== 1'b1)  begin errors++; $display("FAIL eos_guard_run: got %b, required 1", run); end

        // A zero word held through the guard window ends the song.
        exp_sel = m_inc(exp_sel, last_song);
        exp_q.push_back('{exp_sel, base_of(exp_sel)});
        btn_next = 1'b1;
        wait_load(got);
        checks++;
        if (!got) begin errors++; $display("FAIL eos_b_load_timeout: got no load, required load"); end
        note_word = 12'h000;
        step(1);
        checks++;
        if (eos !== 1'b0) begin errors++; $display("FAIL eos_early1: got %b, required 0", eos); end
        step(1);
        checks++;
        if (eos !== 1'b0) begin errors++; $display("FAIL eos_early2: got %b, required 0", eos); end
`ifdef PLAYER_AUTO_ADVANCE_EN
        exp_sel = m_inc(exp_sel, last_song);
        exp_q.push_back('{exp_sel, base_of(exp_sel)});
`endif
        step(1);
        checks++;
        if (eos !== 1'b1) begin errors++; $display("FAIL eos_pulse: got %b, required 1", eos); end
        note_word = 12'h123;
`ifndef PLAYER_AUTO_ADVANCE_EN
        checks++;
        if (run !== 1'b0) begin errors++; $display("FAIL eos_stop_run: got %b, required 0", run); end
`endif
        step(1);
        checks++;
        if (eos !== 1'b0) begin errors++; $display("FAIL eos_width: got %b, required 0", eos); end
        btn_next = 1'b0;
        step(12);
        checks += 4;
        if (eos_cnt != e0 + 1) begin errors++; $display("FAIL eos_count: got %0d, required 1", eos_cnt - e0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL eos_load_count: got %0d pending, required 0", exp_q.size()); end
        if (sel !== exp_sel)   begin errors++; $display("FAIL eos_sel: got %0d, required %0d", sel, exp_sel); end
`ifdef PLAYER_AUTO_ADVANCE_EN
        if (run !== 1'b1)      begin errors++; $display("FAIL eos_auto_run: got %b, required 1", run); end
`else
        if (run !== 1'b0)      begin errors++; $display("FAIL eos_stop_run_late: got %b, required 0", run); end
`endif
    endtask

    task automatic test_reset_midplay;
        if (run !== 1'b1) begin
            exp_q.push_back('{exp_sel, base_of(exp_sel)});
            tap(P_PAUSE);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (sel !== 3'd0)            begin errors++; $display("FAIL rst_mid_sel: got %0d, required 0", sel); end
        if (start_addr !== 16'h0000) begin errors++; $display("FAIL rst_mid_addr: got %h, required 0000", start_addr); end
        if (load !== 1'b0)           begin errors++; $display("FAIL rst_mid_load: got %b, required 0", load); end
        if (run !== 1'b0)            begin errors++; $display("FAIL rst_mid_run: got %b, required 0", run); end
        if (eos !== 1'b0)            begin errors++; $display("FAIL rst_mid_eos: got %b, required 0", eos); end
        btn_pause = 1'b1;
        exp_sel = 3'd0;
        step(3);
        rst = 1'b0;
        exp_q.push_back('{3'd0, 16'h0040});
        step(4);
        checks++;
        if (exp_q.size() != 1) begin errors++; $display("FAIL rst_hold_early: got %0d pending, required 1", exp_q.size()); end
        step(10);
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rst_hold_load: got %0d pending, required 0", exp_q.size()); end
        if (run !== 1'b1)      begin errors++; $display("FAIL rst_hold_run: got %b, required 1", run); end
        btn_pause = 1'b0;
        step(12);
    endtask

    task automatic test_no_double;
        checks++;
        if (dbl_cnt != 0) begin errors++; $display("FAIL strobe_width: got %0d double pulses, required 0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_bounce();
        test_wrap();
        test_priority();
        test_pause_resume();
        test_eos();
        test_reset_midplay();
        test_no_double();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
